// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch frontend.
//   fq_entry_t  : one fetch-queue slot {pc, instr, pred_taken, pred_target, filled}
//   btb_entry_t : one BTB line {valid, tag, target, ctr}
//   btb_idx_w / btb_tag_w : BTB index and tag widths for a given XLEN / entry count
//   ctr_inc / ctr_dec     : 2-bit saturating counter steps
package fetch_pkg;

   // Entry structs are sized for this datapath width; XLEN of the users must match.
   localparam int unsigned FetchXlen = 32;
   // Outstanding-stale-response counter width; stale responses beyond 2**KillW-1 unsupported.
   localparam int unsigned KillW = 8;

   typedef struct packed {
      logic [FetchXlen-1:0] pc;
      logic [FetchXlen-1:0] instr;
      logic                 pred_taken;
      logic [FetchXlen-1:0] pred_target;
      logic                 filled;
   } fq_entry_t;

   // Tag field is wide enough for the smallest legal BTB; unused upper bits stay zero.
   typedef struct packed {
      logic                 valid;
      logic [FetchXlen-3:0] tag;
      logic [FetchXlen-1:0] target;
      logic [1:0]           ctr;
   } btb_entry_t;

   function automatic int unsigned btb_idx_w(input int unsigned entries);
      return $clog2(entries);
   endfunction

   function automatic int unsigned btb_tag_w(input int unsigned xlen, input int unsigned entries);
      return xlen - $clog2(entries) - 2;
   endfunction

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
//   clk, reset        : clock, synchronous active-high reset (clears all valid bits)
//   lookup_pc_i       : combinational lookup address
//   pred_taken_o      : hit and counter in a taken state
//   pred_target_o     : stored target of the indexed line
//   upd_*_i           : resolved-branch update, applied at the clock edge
// A same-cycle lookup sees the contents before the update.
module fetch_btb
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN        = FetchXlen,
   parameter int unsigned BTB_ENTRIES = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] lookup_pc_i,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            upd_valid_i,
   input  logic [XLEN-1:0] upd_pc_i,
   input  logic            upd_taken_i,
   input  logic [XLEN-1:0] upd_target_i
);

   localparam int unsigned IdxW = btb_idx_w(BTB_ENTRIES);
   localparam int unsigned TagW = btb_tag_w(XLEN, BTB_ENTRIES);

   typedef logic [FetchXlen-3:0] tag_t;

   btb_entry_t        btb_q [BTB_ENTRIES];
   logic [IdxW-1:0]   lk_idx, up_idx;
   tag_t              lk_tag, up_tag;
   logic              up_hit;
   logic [1:0]        up_ctr;
   logic              unused_pc_lsbs;

   assign unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

   always_comb begin
      lk_idx            = lookup_pc_i[IdxW+1:2];
      lk_tag            = '0;
      lk_tag[TagW-1:0]  = lookup_pc_i[XLEN-1 -: TagW];
      up_idx            = upd_pc_i[IdxW+1:2];
      up_tag            = '0;
      up_tag[TagW-1:0]  = upd_pc_i[XLEN-1 -: TagW];
      pred_taken_o      = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag) &&
                          btb_q[lk_idx].ctr[1];
      pred_target_o     = btb_q[lk_idx].target;
      up_hit            = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);
      up_ctr            = btb_q[up_idx].ctr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btb_q <= '{default: '0};
      end else if (upd_valid_i) begin
         if (up_hit) begin
            btb_q[up_idx].ctr <= upd_taken_i ? ctr_inc(up_ctr) : ctr_dec(up_ctr);
            if (upd_taken_i) btb_q[up_idx].target <= upd_target_i;
         end else if (upd_taken_i) begin
            // Taken miss allocates (or replaces) the line weakly taken.
            btb_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target_i, ctr: 2'b10};
         end
      end
   end

endmodule

// File: rtl/fetch_queue_frontend.sv
// Instruction fetch frontend: BTB-predicted fetch PC, multiple outstanding memory
// requests over req/gnt/rvalid, and a QDEPTH-entry in-order fetch queue to decode.
//   clk, reset                  : clock, synchronous active-high reset
//   imem_req/addr/gnt           : fetch request handshake (addr = current fetch PC)
//   imem_rvalid/rdata           : in-order responses
//   out_valid/ready, out_*      : head of fetch queue to decode (no output register)
//   redirect_valid/pc           : flush queue and restart fetch; wins over everything
//   upd_valid/pc/taken/target   : resolved branch training for the BTB
module fetch_queue_frontend
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter int unsigned     QDEPTH      = 4,
   parameter int unsigned     BTB_ENTRIES = 16,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_instr,
   output logic            out_pred_taken,
   output logic [XLEN-1:0] out_pred_target,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);

   localparam int unsigned AW   = $clog2(QDEPTH);
   localparam int unsigned PtrW = AW + 1;

   typedef logic [PtrW-1:0] ptr_t;

   fq_entry_t        q_mem_q [QDEPTH];
   ptr_t             head_q, head_d, tail_q, tail_d, fill_q, fill_d;
   logic [XLEN-1:0]  fpc_q, fpc_d;
   logic [KillW-1:0] kill_q, kill_d;

   logic             pred_taken;
   logic [XLEN-1:0]  pred_target, pred_next;
   logic             q_empty, q_full, grant, pop, fill, resp_live;
   ptr_t             unfilled;
   fq_entry_t        head_e;

   fetch_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk           (clk),
      .reset         (reset),
      .lookup_pc_i   (fpc_q),
      .pred_taken_o  (pred_taken),
      .pred_target_o (pred_target),
      .upd_valid_i   (upd_valid),
      .upd_pc_i      (upd_pc),
      .upd_taken_i   (upd_taken),
      .upd_target_i  (upd_target)
   );

   always_comb begin
      q_empty   = (head_q == tail_q);
      q_full    = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
      // Entries between fill and tail are allocated but still awaiting their response.
      unfilled  = tail_q - fill_q;
      head_e    = q_mem_q[head_q[AW-1:0]];
      pred_next = pred_taken ? pred_target : fpc_q + XLEN'(4);

      imem_req        = !reset && !redirect_valid && !q_full;
      imem_addr       = fpc_q;
      out_valid       = !reset && !q_empty && head_e.filled;
      out_pc          = reset ? '0 : head_e.pc;
      out_instr       = reset ? '0 : head_e.instr;
      out_pred_taken  = reset ? 1'b0 : head_e.pred_taken;
      out_pred_target = reset ? '0 : head_e.pred_target;

      grant     = imem_req && imem_gnt;
      pop       = out_valid && out_ready && !redirect_valid;
      resp_live = imem_rvalid && (kill_q == '0);
      fill      = resp_live && (fill_q != tail_q) && !redirect_valid;

      head_d = head_q;
      tail_d = tail_q;
      fill_d = fill_q;
      fpc_d  = fpc_q;
      kill_d = kill_q;
      if (redirect_valid) begin
         head_d = tail_q;
         fill_d = tail_q;
         fpc_d  = redirect_pc;
         // Every unfilled slot still has a response in flight; the one arriving now is
         // consumed here, whether it was already stale or belonged to a flushed slot.
         kill_d = kill_q + KillW'(unfilled);
         if (imem_rvalid && (kill_d != '0)) kill_d = kill_d - KillW'(1);
      end else begin
         if (imem_rvalid && !resp_live) kill_d = kill_q - KillW'(1);
         if (fill) fill_d = fill_q + ptr_t'(1);
         if (pop) head_d = head_q + ptr_t'(1);
         if (grant) begin
            tail_d = tail_q + ptr_t'(1);
            fpc_d  = pred_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_mem_q <= '{default: '0};
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         fpc_q   <= RESET_PC;
         kill_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         fill_q <= fill_d;
         fpc_q  <= fpc_d;
         kill_q <= kill_d;
         if (grant) begin
            q_mem_q[tail_q[AW-1:0]] <= '{pc: fpc_q, instr: '0, pred_taken: pred_taken,
                                         pred_target: pred_next, filled: 1'b0};
         end
         if (fill) begin
            q_mem_q[fill_q[AW-1:0]].instr  <= imem_rdata;
            q_mem_q[fill_q[AW-1:0]].filled <= 1'b1;
         end
      end
   end

   // A live response must always have an unfilled slot waiting for it.
   resp_has_owner: assert property (@(posedge clk) disable iff (reset)
      (imem_rvalid && (kill_q == '0)) |-> (fill_q != tail_q));

endmodule
